// File: rtl/mem_bus_pkg.sv
// Shared definitions for the RAM-port arbiter: FSM state encoding and one-hot grant codes.
// Grant codes double as the owner select for the RAM-side mux.
package mem_bus_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACCESS  = 2'd1;
   localparam logic [1:0] ST_RESPOND = 2'd2;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_REQ0 = 2'b01;
   localparam logic [1:0] GRANT_REQ1 = 2'b10;

   function automatic logic [1:0] grant_of(input logic idx);
      return idx ? GRANT_REQ1 : GRANT_REQ0;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational; zero latency.
// On a tie the requester that was not served last wins; no valids gives GRANT_NONE.
module rr_arbiter2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last_grant,
   output logic [1:0] pick
);
   import mem_bus_pkg::*;

   always_comb begin
      pick = GRANT_NONE;
      if (valid0 && valid1) begin
         pick = grant_of(~last_grant);
      end else if (valid0) begin
         pick = GRANT_REQ0;
      end else if (valid1) begin
         pick = GRANT_REQ1;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between two valid/ready masters, one access at a time; best case 3 cycles per access.
// Requesters are stalled until their ready pulse; a RAM that never answers is aborted after TIMEOUT_CYCLES.
module ram_arbiter #(
   parameter int ADDR_WIDTH     = 15,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [3:0]            req0_wstrb,
   input  logic [31:0]           req0_wdata,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [3:0]            req1_wstrb,
   input  logic [31:0]           req1_wdata,
   output logic                  req1_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  mem_cs,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_write_data,
   input  logic [31:0]           mem_read_data,
   input  logic                  mem_ready,
   output logic [1:0]            grant,
   output logic                  timeout
);
   import mem_bus_pkg::*;

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   logic [1:0]       state;
   logic [1:0]       grant_reg;
   logic             last_grant;
   logic [CNT_W-1:0] tmo_cnt;
   logic [31:0]      rdata_reg;
   logic             timeout_reg;
   logic [1:0]       pick;
   logic             tmo_hit;
   logic             in_access;
   logic             in_respond;
   logic             sel1;

   rr_arbiter2 u_arb (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant),
      .pick       (pick)
   );

   assign in_access  = (state == ST_ACCESS);
   assign in_respond = (state == ST_RESPOND);
   assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant_reg   <= GRANT_NONE;
         last_grant  <= 1'b1;
         tmo_cnt     <= '0;
         rdata_reg   <= '0;
         timeout_reg <= 1'b0;
      end else begin
         timeout_reg <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick != GRANT_NONE) begin
                  grant_reg <= pick;
                  tmo_cnt   <= '0;
                  state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // A RAM answer in the last allowed cycle still counts as success.
               if (mem_ready) begin
                  rdata_reg <= mem_read_data;
                  state     <= ST_RESPOND;
               end else if (tmo_hit) begin
                  rdata_reg   <= '0;
                  timeout_reg <= 1'b1;
                  state       <= ST_RESPOND;
               end else if (tmo_cnt != {CNT_W{1'b1}}) begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            ST_RESPOND: begin
               last_grant <= grant_reg[1];
               grant_reg  <= GRANT_NONE;
               state      <= ST_IDLE;
            end
            default: begin
               grant_reg <= GRANT_NONE;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req0_ready = in_respond && grant_reg[0];
   assign req1_ready = in_respond && grant_reg[1];
   assign rsp_rdata  = rdata_reg;
   assign grant      = grant_reg;
   assign timeout    = timeout_reg;

   // RAM side follows the registered owner only, never the live valids.
   assign sel1           = grant_reg[1];
   assign mem_cs         = in_access;
   assign mem_we         = in_access ? (sel1 ? req1_wstrb : req0_wstrb) : 4'h0;
   assign mem_address    = in_access ? (sel1 ? req1_addr  : req0_addr)  : '0;
   assign mem_write_data = in_access ? (sel1 ? req1_wdata : req0_wdata) : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: transaction-level model predicts service order and responses,
// a negedge monitor compares every RAM access and every ready pulse against the predicted queues.
module tb_ram_arbiter;
   localparam int AW    = 15;
   localparam int TO    = 4;
   localparam int WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 1'b0;
   logic [AW-1:0] req0_addr = '0;
   logic [3:0]    req0_wstrb = '0;
   logic [31:0]   req0_wdata = '0;
   logic          req1_valid = 1'b0;
   logic [AW-1:0] req1_addr = '0;
   logic [3:0]    req1_wstrb = '0;
   logic [31:0]   req1_wdata = '0;
   logic          req0_ready, req1_ready;
   logic [31:0]   rsp_rdata;
   logic          mem_cs;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_write_data;
   logic [31:0]   mem_read_data;
   logic          mem_ready;
   logic [1:0]    grant;
   logic          timeout;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wstrb(req0_wstrb),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wstrb(req1_wstrb),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp_rdata(rsp_rdata),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .mem_ready(mem_ready), .grant(grant), .timeout(timeout)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input int a);
      if (a == 'h10) return 32'hDEADBEEF;
      return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   typedef struct {
      logic [AW-1:0] addr;
      logic [3:0]    wstrb;
      logic [31:0]   wdata;
      int            delay;
   } req_t;

   typedef struct {
      int            port;
      logic [AW-1:0] addr;
      logic [3:0]    we;
      logic [31:0]   wdata;
      int            len;
      logic [31:0]   rdata;
      logic          tmo;
   } exp_t;

   function automatic req_t mk(input logic [AW-1:0] a, input logic [3:0] s,
                               input logic [31:0] d, input int dl);
      req_t r;
      r.addr = a; r.wstrb = s; r.wdata = d; r.delay = dl;
      return r;
   endfunction

   // ---------------- RAM model: answers after a per-access delay taken from delay_q
   logic [31:0] ram [0:WORDS-1];
   bit          ram_init = 1'b0;
   int          wait_cnt = 0;
   int          cur_delay = 0;
   bit          loaded = 1'b0;
   int          delay_q[$];

   assign mem_read_data = ram[mem_address];
   assign mem_ready     = mem_cs && (wait_cnt >= cur_delay);

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
         ram_init <= 1'b1;
      end else if (mem_cs && mem_ready) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
      end
      if (!mem_cs || mem_ready) wait_cnt <= 0;
      else                      wait_cnt <= wait_cnt + 1;
      if (mem_cs) loaded <= 1'b0;
      else if (!loaded && delay_q.size() > 0) begin
         cur_delay <= delay_q.pop_front();
         loaded    <= 1'b1;
      end
   end

   // ---------------- reference model
   req_t        q0[$], q1[$];
   exp_t        exp_acc_q[$], exp_rsp_q[$];
   logic [31:0] ref_mem [0:WORDS-1];
   int          model_last = 1;

   task automatic plan_batch();
      int   i0 = 0;
      int   i1 = 0;
      int   p;
      req_t r;
      exp_t e;
      while (i0 < q0.size() || i1 < q1.size()) begin
         if (i0 < q0.size() && i1 < q1.size()) p = 1 - model_last;
         else if (i0 < q0.size())              p = 0;
         else                                  p = 1;
         if (p == 0) begin r = q0[i0]; i0++; end
         else        begin r = q1[i1]; i1++; end
         model_last = p;
         e.port = p; e.addr = r.addr; e.we = r.wstrb; e.wdata = r.wdata;
         if (r.delay >= TO) begin
            e.len = TO; e.rdata = 32'h0; e.tmo = 1'b1;
         end else begin
            e.len = r.delay + 1; e.rdata = ref_mem[r.addr]; e.tmo = 1'b0;
            for (int b = 0; b < 4; b++)
               if (r.wstrb[b]) ref_mem[r.addr][8*b +: 8] = r.wdata[8*b +: 8];
         end
         exp_acc_q.push_back(e);
         exp_rsp_q.push_back(e);
         delay_q.push_back(r.delay);
      end
   endtask

   // Drives both queues; each port re-requests the cycle after it drops valid.
   task automatic run_batch(output int first_lat);
      int t = 0;
      int t_raise = -1;
      first_lat = -1;
      plan_batch();
      while ((q0.size() > 0 || q1.size() > 0) && t < 3000) begin
         if (req0_valid && req0_ready) begin
            q0.delete(0); req0_valid = 1'b0;
            if (first_lat < 0) first_lat = t - t_raise;
         end else if (!req0_valid && q0.size() > 0) begin
            req0_addr = q0[0].addr; req0_wstrb = q0[0].wstrb; req0_wdata = q0[0].wdata;
            req0_valid = 1'b1;
            if (t_raise < 0) t_raise = t;
         end
         if (req1_valid && req1_ready) begin
            q1.delete(0); req1_valid = 1'b0;
            if (first_lat < 0) first_lat = t - t_raise;
         end else if (!req1_valid && q1.size() > 0) begin
            req1_addr = q1[0].addr; req1_wstrb = q1[0].wstrb; req1_wdata = q1[0].wdata;
            req1_valid = 1'b1;
            if (t_raise < 0) t_raise = t;
         end
         @(posedge clk); #1; t++;
      end
      if (t >= 3000) begin
         check("batch_completion", 32'(t), 32'(0));
         q0.delete(); q1.delete();
         req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   // ---------------- monitor
   int            acc_len = 0;
   logic [AW-1:0] a_addr;
   logic [3:0]    a_we;
   logic [31:0]   a_wd;
   logic [1:0]    a_grant;
   exp_t          mon_e;

   always @(negedge clk) begin
      if (reset) begin
         acc_len = 0;
      end else begin
         if (mem_cs) begin
            if (acc_len == 0) begin
               a_addr = mem_address; a_we = mem_we; a_wd = mem_write_data; a_grant = grant;
            end
            acc_len++;
         end else if (acc_len > 0) begin
            if (exp_acc_q.size() == 0) begin
               check("acc_unexpected", 32'(acc_len), 32'(0));
            end else begin
               mon_e = exp_acc_q.pop_front();
               check("acc_len",   32'(acc_len), 32'(mon_e.len));
               check("acc_addr",  32'(a_addr),  32'(mon_e.addr));
               check("acc_we",    32'(a_we),    32'(mon_e.we));
               check("acc_wdata", a_wd,         mon_e.wdata);
               check("acc_grant", 32'(a_grant), (mon_e.port == 1) ? 32'd2 : 32'd1);
            end
            acc_len = 0;
         end
         if (req0_ready || req1_ready) begin
            if (exp_rsp_q.size() == 0) begin
               check("rsp_unexpected", 32'({req1_ready, req0_ready}), 32'(0));
            end else begin
               mon_e = exp_rsp_q.pop_front();
               check("rsp_port",    32'({req1_ready, req0_ready}), (mon_e.port == 1) ? 32'd2 : 32'd1);
               check("rsp_grant",   32'(grant),   (mon_e.port == 1) ? 32'd2 : 32'd1);
               check("rsp_rdata",   rsp_rdata,    mon_e.rdata);
               check("rsp_timeout", 32'(timeout), 32'(mon_e.tmo));
            end
         end else if (timeout) begin
            check("timeout_stray", 32'(timeout), 32'(0));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_cs"},    32'(mem_cs),      32'(0));
      check({tag, "_mem_we"},    32'(mem_we),      32'(0));
      check({tag, "_mem_addr"},  32'(mem_address), 32'(0));
      check({tag, "_mem_wdata"}, mem_write_data,   32'(0));
      check({tag, "_ready"},     32'({req1_ready, req0_ready}), 32'(0));
      check({tag, "_rdata"},     rsp_rdata,        32'(0));
      check({tag, "_grant"},     32'(grant),       32'(0));
      check({tag, "_timeout"},   32'(timeout),     32'(0));
   endtask

   // ---------------- stimulus
   initial begin
      int lat;
      int n0, n1;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // Contention straight out of reset: strict alternation starting at req0.
      for (int i = 0; i < 3; i++) begin
         q0.push_back(mk(AW'(32'h20 + i), 4'h0, 32'h0, 0));
         q1.push_back(mk(AW'(32'h40 + i), 4'h0, 32'h0, 0));
      end
      run_batch(lat);

      q0.push_back(mk(15'h0010, 4'h0, 32'h0, 0));
      run_batch(lat);
      check("lat_single_read", 32'(lat), 32'd2);

      q1.push_back(mk(15'h7FFF, 4'h3, 32'h12345678, 0));
      run_batch(lat);
      check("lat_write", 32'(lat), 32'd2);

      q0.push_back(mk(15'h7FFF, 4'h0, 32'h0, 1));
      run_batch(lat);
      check("lat_wait1", 32'(lat), 32'd3);

      q0.push_back(mk(15'h0010, 4'h0, 32'h0, 9));
      run_batch(lat);
      check("lat_timeout", 32'(lat), 32'(TO + 1));

      q1.push_back(mk(15'h0010, 4'h0, 32'h0, TO - 1));
      run_batch(lat);
      check("lat_race", 32'(lat), 32'(TO + 1));

      // Reset while the RAM is stalling: everything drops at once, no response.
      delay_q.push_back(9);
      req0_addr = 15'h0055; req0_wstrb = 4'h0; req0_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_cs", 32'(mem_cs), 32'd1);
      #1 reset = 1'b1;
      #1;
      check_all_zero("mid_reset");
      req0_valid = 1'b0;
      model_last = 1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      q0.push_back(mk(15'h0011, 4'h0, 32'h0, 0));
      q1.push_back(mk(15'h0012, 4'h0, 32'h0, 0));
      run_batch(lat);

      for (int k = 0; k < 40; k++) begin
         n0 = $urandom_range(0, 3);
         n1 = $urandom_range(0, 3);
         for (int j = 0; j < n0 + n1; j++) begin
            logic [AW-1:0] a;
            logic [3:0]    s;
            int            r;
            a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15))
                                            : AW'(32'h7FF0 + $urandom_range(0, 15));
            s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            r = $urandom_range(0, 9);
            if (j < n0) q0.push_back(mk(a, s, $urandom, (r < 5) ? 0 : r - 4));
            else        q1.push_back(mk(a, s, $urandom, (r < 5) ? 0 : r - 4));
         end
         if (n0 + n1 > 0) run_batch(lat);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (10) @(posedge clk);
      #1;
      check("exp_acc_left", 32'(exp_acc_q.size()), 32'(0));
      check("exp_rsp_left", 32'(exp_rsp_q.size()), 32'(0));
      check("delay_left",   32'(delay_q.size()),   32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
